hazard_ctrl: RTL

//  Pipeline sequencer for the decode stage: tracks in-flight destinations (EX, MEM, WB) in a

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard sequencer: EX/MEM/WB shadow scoreboard, stalls, forwarding selects.
// Optional stall counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_exec,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rp,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_rd,
    input  logic              id_jr,
    input  logic              id_jump,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_load,
    output logic              stall,
    output logic              bubble_ex,
    output logic              kill_if,
    output logic [1:0]        id_fwd_p,
    output logic [1:0]        id_fwd_j,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [1:0]        ex_fwd_d,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_v_q, mem_v_q, wb_v_q;
    logic [REG_AW-1:0] ex_d_q, mem_d_q, wb_d_q;
    logic              ex_ld_q, mem_ld_q;
    logic              load_use, p_hz, j_hz;
    logic [1:0]        fa_d, fb_d, fd_d;

    function automatic logic hit(input logic [REG_AW-1:0] x,
                                 input logic v,
                                 input logic [REG_AW-1:0] d);
        return v && (d == x) && (x != '0);
    endfunction

    function automatic logic dec_hz(input logic [REG_AW-1:0] x,
                                    input logic ev, input logic [REG_AW-1:0] ed,
                                    input logic mv, input logic [REG_AW-1:0] md,
                                    input logic mld);
        return hit(x, ev, ed) || (mld && hit(x, mv, md));
    endfunction

    // Hazard detection and decode-stage forwarding, zero latency
    always_comb begin
        load_use = ex_ld_q &&
                   ((id_use_rs && hit(id_rs, ex_v_q, ex_d_q)) ||
                    (id_use_rt && hit(id_rt, ex_v_q, ex_d_q)) ||
                    (id_use_rd && hit(id_rd, ex_v_q, ex_d_q)));
        p_hz = dec_hz(id_rp, ex_v_q, ex_d_q, mem_v_q, mem_d_q, mem_ld_q);
        j_hz = id_jr && dec_hz(id_rs, ex_v_q, ex_d_q, mem_v_q, mem_d_q, mem_ld_q);
        stall     = id_valid && (load_use || p_hz || j_hz);
        bubble_ex = stall;
        kill_if   = id_valid && id_jump && id_exec && !stall;
        id_fwd_p = 2'd0;
        id_fwd_j = 2'd0;
        if (id_valid) begin
            if (hit(id_rp, mem_v_q, mem_d_q))     id_fwd_p = 2'd1;
            else if (hit(id_rp, wb_v_q, wb_d_q))  id_fwd_p = 2'd2;
            if (hit(id_rs, mem_v_q, mem_d_q))     id_fwd_j = 2'd1;
            else if (hit(id_rs, wb_v_q, wb_d_q))  id_fwd_j = 2'd2;
        end
    end

    // Next EX forwarding selects; a stalled or empty slot carries no forwarding
    always_comb begin
        fa_d = 2'd0;
        fb_d = 2'd0;
        fd_d = 2'd0;
        if (id_valid && !stall) begin
            if (hit(id_rs, ex_v_q, ex_d_q))        fa_d = 2'd1;
            else if (hit(id_rs, mem_v_q, mem_d_q)) fa_d = 2'd2;
            if (hit(id_rt, ex_v_q, ex_d_q))        fb_d = 2'd1;
            else if (hit(id_rt, mem_v_q, mem_d_q)) fb_d = 2'd2;
            if (hit(id_rd, ex_v_q, ex_d_q))        fd_d = 2'd1;
            else if (hit(id_rd, mem_v_q, mem_d_q)) fd_d = 2'd2;
        end
    end

    // Scoreboard shift and registered EX forwarding selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q   <= 1'b0;
            mem_v_q  <= 1'b0;
            wb_v_q   <= 1'b0;
            ex_d_q   <= '0;
            mem_d_q  <= '0;
            wb_d_q   <= '0;
            ex_ld_q  <= 1'b0;
            mem_ld_q <= 1'b0;
            ex_fwd_a <= 2'd0;
            ex_fwd_b <= 2'd0;
            ex_fwd_d <= 2'd0;
        end else begin
            ex_v_q   <= id_valid && id_exec && id_wr && !stall;
            ex_d_q   <= id_dest;
            ex_ld_q  <= id_load;
            mem_v_q  <= ex_v_q;
            mem_d_q  <= ex_d_q;
            mem_ld_q <= ex_ld_q;
            wb_v_q   <= mem_v_q;
            wb_d_q   <= mem_d_q;
            ex_fwd_a <= fa_d;
            ex_fwd_b <= fb_d;
            ex_fwd_d <= fd_d;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
